// File: rtl/ahb2apb_ctrl_param.sv
// ahb2apb_ctrl_param: AHB-Lite to APB3 bridge with wait states, slave error, timeout and address checks
module ahb2apb_ctrl_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int SLV_LSB = 28,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [ADDR_W-1:0] paddr,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [2:0]        state_o
);
    localparam int IDX_W = NSLV > 1 ? $clog2(NSLV) : 1;
    localparam int TO_W  = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W:0]  NSLV_L  = (IDX_W + 1)'(NSLV);
    localparam logic [2:0]      SZ_MAX  = 3'($clog2(DATA_W / 8));
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE = 3'd0, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] hidx;
    logic [TO_W-1:0]  cnt;
    logic             accept;
    logic             addr_err;

    assign hidx     = haddr[SLV_LSB +: IDX_W];
    assign accept   = hsel && hready && (htrans inside {2'b10, 2'b11});
    assign addr_err = ({1'b0, hidx} >= NSLV_L) || (hsize > SZ_MAX);
    assign state_o  = state;

    // Bridge FSM; every output is registered and set on the edge that enters its state
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            paddr     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    hreadyout <= 1'b0;
                    if (addr_err) begin
                        state <= ERR1;
                        hresp <= 1'b1;
                    end else begin
                        paddr  <= haddr;
                        pwrite <= hwrite;
                        idx    <= hidx;
                        if (hwrite) state <= WWAIT;
                        else begin
                            state <= SETUP;
                            psel  <= (NSLV)'(1) << hidx;
                            cnt   <= '0;
                        end
                    end
                end
                WWAIT: begin
                    pwdata <= hwdata;
                    psel   <= (NSLV)'(1) << idx;
                    cnt    <= '0;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: if (pready) begin
                    psel    <= '0;
                    penable <= 1'b0;
                    if (pslverr) begin
                        state <= ERR1;
                        hresp <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        hreadyout <= 1'b1;
                        if (!pwrite) hrdata <= prdata;
                    end
                end else if (TIMEOUT > 0) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == TO_LAST) begin
                        state   <= ERR1;
                        hresp   <= 1'b1;
                        psel    <= '0;
                        penable <= 1'b0;
                    end
                end
                ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= ERR2;
                end
                ERR2: begin
                    hresp <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
